// File: rtl/BUS_IF.sv
// Codma bus: one master issues read/write requests, one memory slave answers
// with a grant, then a read-data burst, a write-data burst, or an error pulse.
interface BUS_IF;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  size;
  logic        grant;
  logic        read_valid;
  logic [63:0] read_data;
  logic        write_valid;
  logic [63:0] write_data;
  logic        error;

  modport slave (
    input  read, write, addr, size, write_valid, write_data,
    output grant, read_valid, read_data, error
  );

  modport master (
    output read, write, addr, size, write_valid, write_data,
    input  grant, read_valid, read_data, error
  );
endinterface

// File: rtl/ip_codma_mem_slave.sv
// 64-bit word memory target on the codma bus: one request at a time,
// 1/2/4-beat bursts, a one-cycle grant and then data or a one-cycle error.
module ip_codma_mem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic  clk,
  input  logic  reset_n,
  BUS_IF.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_size;
  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_beat;
  logic        r_grant;
  logic        r_read_valid;
  logic [63:0] r_read_data;
  logic        r_error;
  logic [63:0] r_mem [DEPTH];

  logic [31:0]   w_offset;
  logic [31:0]   w_index;
  logic [2:0]    w_beats;
  logic          w_size_ok;
  logic          w_req_err;
  logic          w_last;
  logic [1:0]    w_rd_beat;
  logic [AW-1:0] w_base_idx;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_wr_en;

  assign w_offset = r_addr - BASE_ADDR;
  assign w_index  = w_offset >> 3;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_beats   = 3'd0;
    w_size_ok = 1'b0;
    case (r_size)
      4'h1: begin w_beats = 3'd1; w_size_ok = 1'b1; end
      4'h2: begin w_beats = 3'd2; w_size_ok = 1'b1; end
      4'h4: begin w_beats = 3'd4; w_size_ok = 1'b1; end
      default: ;
    endcase
  end

  // Range test is done 33 bits wide so a huge index cannot wrap past DEPTH.
  assign w_req_err = !w_size_ok
                  || (r_addr[2:0] != 3'b000)
                  || (r_addr < BASE_ADDR)
                  || (({1'b0, w_index} + 33'(w_beats)) > 33'(DEPTH))
                  || (r_rd && r_wr);

  assign w_base_idx = w_index[AW-1:0];
  assign w_last     = ({1'b0, r_beat} == (w_beats - 3'd1));
  assign w_rd_beat  = (r_state == S_GRANT) ? 2'd0 : (r_beat + 2'd1);
  assign w_rd_idx   = w_base_idx + AW'(w_rd_beat);
  assign w_wr_idx   = w_base_idx + AW'(r_beat);
  assign w_wr_en    = (r_state == S_WDATA) && bus.write_valid;

  // NOTE: sequential state uses <= only, so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_size       <= 4'h0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_beat       <= 2'd0;
      r_grant      <= 1'b0;
      r_read_valid <= 1'b0;
      r_read_data  <= 64'h0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.read || bus.write) begin
            r_addr  <= bus.addr;
            r_size  <= bus.size;
            r_rd    <= bus.read;
            r_wr    <= bus.write;
            r_grant <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_grant <= 1'b0;
          r_beat  <= 2'd0;
          if (w_req_err) begin
            r_error <= 1'b1;
            r_state <= S_ERR;
          end else if (r_rd) begin
            r_read_valid <= 1'b1;
            r_read_data  <= r_mem[w_rd_idx];
            r_state      <= S_RDATA;
          end else begin
            r_state <= S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_last) begin
            r_read_valid <= 1'b0;
            r_read_data  <= 64'h0;
            r_beat       <= 2'd0;
            r_state      <= S_IDLE;
          end else begin
            r_beat      <= r_beat + 2'd1;
            r_read_data <= r_mem[w_rd_idx];
          end
        end
        S_WDATA: begin
          if (bus.write_valid) begin
            if (w_last) begin
              r_beat  <= 2'd0;
              r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        S_ERR: begin
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across reset_n.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= bus.write_data;
  end

  assign bus.grant      = r_grant;
  assign bus.read_valid = r_read_valid;
  assign bus.read_data  = r_read_data;
  assign bus.error      = r_error;

endmodule
